// File: rtl/cfg_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_guard_pkg
// Description : Shared definitions for the configuration write guard: FSM
//               state encoding, address classes and default key/window values.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_guard_pkg;

    // Guard FSM state encoding
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_ARMED    = 2'b01,
        ST_UNLOCKED = 2'b10
    } guard_state_t;

    // Address class of an incoming write
    typedef enum logic [1:0] {
        CLS_OPEN = 2'b00,
        CLS_PROT = 2'b01,
        CLS_KEY  = 2'b10
    } addr_cls_t;

    // Default protection window and key values
    localparam logic [5:0] C_PROT_LO   = 6'h30;
    localparam logic [5:0] C_PROT_HI   = 6'h3E;
    localparam logic [5:0] C_KEY_ADDR  = 6'h3F;
    localparam logic [7:0] C_KEY1      = 8'hA5;
    localparam logic [7:0] C_KEY2      = 8'h5A;
    localparam int         C_UNLOCK_WR = 4;

endpackage : cfg_guard_pkg
`default_nettype wire

// File: rtl/cfg_wr_guard.sv
`default_nettype none
// ============================================================================
// Module      : cfg_wr_guard
// Description : Write-protection stage between the command interpreter and the
//               configuration register file. Forwards writes one cycle later,
//               gating a protected address window behind a two-write key
//               sequence with a limited write credit. Rejected writes set a
//               sticky error flag and a saturating rejection count.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_wr_guard
    import cfg_guard_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] PROT_LO   = ADDR_W'(C_PROT_LO),
    parameter logic [ADDR_W-1:0] PROT_HI   = ADDR_W'(C_PROT_HI),
    parameter logic [ADDR_W-1:0] KEY_ADDR  = ADDR_W'(C_KEY_ADDR),
    parameter logic [DATA_W-1:0] KEY1      = DATA_W'(C_KEY1),
    parameter logic [DATA_W-1:0] KEY2      = DATA_W'(C_KEY2),
    parameter int                UNLOCK_WR = C_UNLOCK_WR
) (
    input  logic              SCK,
    input  logic              NRST,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [DATA_W-1:0] reg_value_i,
    input  logic              wr_en_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_value,
    output logic              wr_en,
    output logic              unlocked,
    output logic              err_rej,
    output logic [3:0]        rej_cnt
);

    localparam logic [3:0] C_CREDIT_INIT = 4'(UNLOCK_WR);

    // Classify a write address as key register, protected window or open
    function automatic addr_cls_t classify(input logic [ADDR_W-1:0] addr);
        if (addr == KEY_ADDR) begin
            return CLS_KEY;
        end else if ((addr >= PROT_LO) && (addr <= PROT_HI)) begin
            return CLS_PROT;
        end else begin
            return CLS_OPEN;
        end
    endfunction

    guard_state_t      state_q, state_d;
    logic [3:0]        credit_q, credit_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_value_q, reg_value_d;
    logic              wr_en_q, wr_en_d;
    logic              unlocked_q, unlocked_d;
    logic              err_rej_q, err_rej_d;
    logic [3:0]        rej_cnt_q, rej_cnt_d;

    addr_cls_t         w_cls;
    logic              w_fwd;
    logic              w_rej;

    assign w_cls = classify(reg_addr_i);

    // Guard FSM: next state, credit, and forward/reject decision per strobe
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        w_fwd    = 1'b0;
        w_rej    = 1'b0;
        if (wr_en_i) begin
            case (state_q)
                ST_ARMED: begin
                    if ((w_cls == CLS_KEY) && (reg_value_i == KEY2)) begin
                        state_d  = ST_UNLOCKED;
                        credit_d = C_CREDIT_INIT;
                    end else begin
                        // Sequence broken: handle this write as if LOCKED
                        state_d = ST_LOCKED;
                        case (w_cls)
                            CLS_KEY:  if (reg_value_i == KEY1) state_d = ST_ARMED;
                            CLS_PROT: w_rej = 1'b1;
                            default:  w_fwd = 1'b1;
                        endcase
                    end
                end
                ST_UNLOCKED: begin
                    case (w_cls)
                        CLS_KEY: begin
                            state_d  = ST_LOCKED;
                            credit_d = 4'd0;
                        end
                        CLS_PROT: begin
                            w_fwd    = 1'b1;
                            credit_d = credit_q - 4'd1;
                            if (credit_q <= 4'd1) begin
                                state_d  = ST_LOCKED;
                                credit_d = 4'd0;
                            end
                        end
                        default: w_fwd = 1'b1;
                    endcase
                end
                default: begin
                    case (w_cls)
                        CLS_KEY:  if (reg_value_i == KEY1) state_d = ST_ARMED;
                        CLS_PROT: w_rej = 1'b1;
                        default:  w_fwd = 1'b1;
                    endcase
                end
            endcase
        end
    end

    // Output stage: forwarded write, status flags and rejection counter
    always_comb begin
        reg_addr_d  = reg_addr_q;
        reg_value_d = reg_value_q;
        wr_en_d     = w_fwd;
        unlocked_d  = (state_d == ST_UNLOCKED);
        err_rej_d   = err_rej_q;
        rej_cnt_d   = rej_cnt_q;
        if (w_fwd) begin
            reg_addr_d  = reg_addr_i;
            reg_value_d = reg_value_i;
        end
        // A rejection in the same cycle as a clear takes priority
        if (w_rej) begin
            err_rej_d = 1'b1;
            if (clr_i) begin
                rej_cnt_d = 4'd1;
            end else if (rej_cnt_q != 4'hF) begin
                rej_cnt_d = rej_cnt_q + 4'd1;
            end
        end else if (clr_i) begin
            err_rej_d = 1'b0;
            rej_cnt_d = 4'd0;
        end
    end

    // State and output registers
    always_ff @(posedge SCK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= ST_LOCKED;
            credit_q    <= 4'd0;
            reg_addr_q  <= '0;
            reg_value_q <= '0;
            wr_en_q     <= 1'b0;
            unlocked_q  <= 1'b0;
            err_rej_q   <= 1'b0;
            rej_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            reg_addr_q  <= reg_addr_d;
            reg_value_q <= reg_value_d;
            wr_en_q     <= wr_en_d;
            unlocked_q  <= unlocked_d;
            err_rej_q   <= err_rej_d;
            rej_cnt_q   <= rej_cnt_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_value = reg_value_q;
    assign wr_en     = wr_en_q;
    assign unlocked  = unlocked_q;
    assign err_rej   = err_rej_q;
    assign rej_cnt   = rej_cnt_q;

endmodule : cfg_wr_guard
`default_nettype wire
